// File: rtl/pps_count_reader.sv
// pps_count_reader: SPI master that reads the 1PPS-latched clock count and turns it into a signed frequency error
// Ports: clk_i/rst_ni clock and async active-low reset; ready_i PPS ready from counter (async);
//   miso_i/sck_o/cs_o SPI master (CPOL=1 CPHA=1, MSB first); count_o last count; error_o count-NOMINAL;
//   valid_o one-clk update strobe; pps_lost_o no ready edge within TIMEOUT; overrun_o ready edge during a read;
//   busy_o read in progress.
module pps_count_reader #(
  parameter int NOMINAL   = 10_000_000,
  parameter int HALF      = 4,
  parameter int SETUP_DLY = 4,
  parameter int TIMEOUT   = 12_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ready_i,
  input  logic        miso_i,
  output logic        sck_o,
  output logic        cs_o,
  output logic [31:0] count_o,
  output logic [31:0] error_o,
  output logic        valid_o,
  output logic        pps_lost_o,
  output logic        overrun_o,
  output logic        busy_o
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] CS_LEAD  = 3'd2;
  localparam logic [2:0] SCK_LOW  = 3'd3;
  localparam logic [2:0] SCK_HIGH = 3'd4;
  localparam logic [2:0] CS_LAG   = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;
  localparam int TW = $clog2((HALF > SETUP_DLY ? HALF : SETUP_DLY) + 1);
  localparam int WW = $clog2(TIMEOUT + 1) < 24 ? 24 : $clog2(TIMEOUT + 1);
  logic [2:0]    sync_q;
  logic          e;
  logic [WW-1:0] wd_q, wd_d;
  logic          pps_lost_q, pps_lost_d;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   shift_q, shift_d, count_q, error_q;
  logic          valid_q, overrun_q, busy_q, sck_q, cs_q;
  logic          tmr_done, load;
  // sync_q[0..1] form the synchronizer, sync_q[2] is the delayed copy for edge detection
  assign e        = sync_q[1] & ~sync_q[2];
  assign tmr_done = tmr_q == '0;
  assign load     = state_q == CS_LAG && tmr_done;
  assign wd_d     = e ? '0 : (wd_q == WW'(TIMEOUT) ? wd_q : wd_q + 1'b1);
  // An edge after a loss only re-arms; the count it latched spans an unknown interval
  assign pps_lost_d = e ? 1'b0 : (pps_lost_q | (wd_q == WW'(TIMEOUT)));
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tmr_d   = tmr_done ? tmr_q : tmr_q - 1'b1;
    case (state_q)
      IDLE: if (e && !pps_lost_q) begin
        state_d = SETUP;
        tmr_d   = TW'(SETUP_DLY - 1);
      end
      SETUP: if (tmr_done) begin
        state_d = CS_LEAD;
        tmr_d   = TW'(HALF - 1);
      end
      CS_LEAD: if (tmr_done) begin
        state_d = SCK_LOW;
        tmr_d   = TW'(HALF - 1);
        bit_d   = 5'd31;
      end
      // miso is sampled on the clk where sck is driven back high
      SCK_LOW: if (tmr_done) begin
        state_d = SCK_HIGH;
        tmr_d   = TW'(HALF - 1);
        shift_d = {shift_q[30:0], miso_i};
      end
      SCK_HIGH: if (tmr_done) begin
        state_d = bit_q == 5'd0 ? CS_LAG : SCK_LOW;
        tmr_d   = TW'(HALF - 1);
        bit_d   = bit_q - 1'b1;
      end
      CS_LAG: if (tmr_done) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      wd_q       <= '0;
      pps_lost_q <= 1'b1;
      state_q    <= IDLE;
      tmr_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      error_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      sck_q      <= 1'b1;
      cs_q       <= 1'b1;
    end else begin
      sync_q     <= {sync_q[1:0], ready_i};
      wd_q       <= wd_d;
      pps_lost_q <= pps_lost_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      valid_q    <= load;
      overrun_q  <= e && state_q != IDLE;
      busy_q     <= state_d != IDLE;
      sck_q      <= state_d != SCK_LOW;
      cs_q       <= !(state_d inside {CS_LEAD, SCK_LOW, SCK_HIGH, CS_LAG});
      if (load) begin
        count_q <= shift_q;
        error_q <= shift_q - 32'(NOMINAL);
      end
    end
  end
  assign sck_o      = sck_q;
  assign cs_o       = cs_q;
  assign count_o    = count_q;
  assign error_o    = error_q;
  assign valid_o    = valid_q;
  assign pps_lost_o = pps_lost_q;
  assign overrun_o  = overrun_q;
  assign busy_o     = busy_q;
endmodule
